// File: rtl/cv_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cv_sweep_scheduler
// Description : Triangular staircase DAC code sequencer for cyclic voltammetry
//               v_init -> v_high -> v_low -> v_init, repeated n_cycles times,
//               with a programmable per-step dwell of at least one DAC frame.
// Revision    : 1.0 - initial release
// ============================================================================
module cv_sweep_scheduler #(
    parameter int FRAME_CLKS = 50,
    parameter int TIMER_W    = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [15:0]        v_init,
    input  logic [15:0]        v_high,
    input  logic [15:0]        v_low,
    input  logic [15:0]        step,
    input  logic [TIMER_W-1:0] step_clks,
    input  logic [7:0]         n_cycles,
    output logic [15:0]        dac_data,
    output logic               sample_strobe,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               dir,
    output logic [7:0]         cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UP     = 3'd1,
        S_DOWN   = 3'd2,
        S_RETURN = 3'd3,
        S_FINAL  = 3'd4
    } state_t;

    localparam logic [TIMER_W-1:0] C_FRAME_CLKS = TIMER_W'(FRAME_CLKS);
    localparam logic [TIMER_W-1:0] C_TIMER_ONE  = TIMER_W'(1);

    state_t             r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] r_eff_clks;
    logic [15:0]        r_v_init;
    logic [15:0]        r_v_high;
    logic [15:0]        r_v_low;
    logic [15:0]        r_eff_step;
    logic [7:0]         r_n_cycles;

    logic               w_dwell_end;
    logic               w_cfg_bad;
    logic [16:0]        w_sum;
    logic [16:0]        w_diff;
    logic [7:0]         w_cnt_next;

    // Last cycle of the current dwell; the next code is registered on this edge
    assign w_dwell_end = (r_state != S_IDLE) && (r_timer == (r_eff_clks - C_TIMER_ONE));

    // An aborting cycle never presents a strobe
    assign sample_strobe = w_dwell_end & ~abort;

    // Vertex ordering and cycle count must be sane before a sweep may begin
    assign w_cfg_bad = (v_low > v_init) || (v_init > v_high) || (n_cycles == 8'd0);

    // 17-bit step arithmetic so that neither end can wrap around
    assign w_sum      = {1'b0, dac_data} + {1'b0, r_eff_step};
    assign w_diff     = {1'b0, dac_data} - {1'b0, r_eff_step};
    assign w_cnt_next = cycle_cnt + 8'd1;

    // Sweep sequencer: config latch, dwell timer, clamped stepping and handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_eff_clks <= '0;
            r_v_init   <= '0;
            r_v_high   <= '0;
            r_v_low    <= '0;
            r_eff_step <= '0;
            r_n_cycles <= '0;
            dac_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            dir        <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_v_init   <= v_init;
                        r_v_high   <= v_high;
                        r_v_low    <= v_low;
                        r_eff_step <= (step == 16'd0) ? 16'd1 : step;
                        r_eff_clks <= (step_clks < C_FRAME_CLKS) ? C_FRAME_CLKS : step_clks;
                        r_n_cycles <= n_cycles;
                        if (w_cfg_bad) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            dac_data  <= v_init;
                            busy      <= 1'b1;
                            dir       <= 1'b1;
                            cycle_cnt <= '0;
                            err       <= 1'b0;
                            r_timer   <= '0;
                            r_state   <= S_UP;
                        end
                    end
                end
                default: begin
                    if (abort) begin
                        r_state  <= S_IDLE;
                        busy     <= 1'b0;
                        dac_data <= r_v_init;
                        r_timer  <= '0;
                    end else if (w_dwell_end) begin
                        r_timer <= '0;
                        case (r_state)
                            S_UP: begin
                                if (w_sum >= {1'b0, r_v_high}) begin
                                    dac_data <= r_v_high;
                                    dir      <= 1'b0;
                                    r_state  <= S_DOWN;
                                end else begin
                                    dac_data <= w_sum[15:0];
                                end
                            end
                            S_DOWN: begin
                                if ($signed(w_diff) <= $signed({1'b0, r_v_low})) begin
                                    dac_data <= r_v_low;
                                    dir      <= 1'b1;
                                    r_state  <= S_RETURN;
                                end else begin
                                    dac_data <= w_diff[15:0];
                                end
                            end
                            S_RETURN: begin
                                if (w_sum >= {1'b0, r_v_init}) begin
                                    dac_data  <= r_v_init;
                                    cycle_cnt <= w_cnt_next;
                                    r_state   <= (w_cnt_next == r_n_cycles) ? S_FINAL : S_UP;
                                end else begin
                                    dac_data <= w_sum[15:0];
                                end
                            end
                            S_FINAL: begin
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                r_state <= S_IDLE;
                            end
                            default: begin
                                r_state <= S_IDLE;
                            end
                        endcase
                    end else begin
                        r_timer <= r_timer + C_TIMER_ONE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cv_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv_sweep_scheduler
// Description : Scoreboard bench for cv_sweep_scheduler; expected strobes and
//               completions are derived from the sweep rules and queued.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv_sweep_scheduler;

    localparam int FRAME = 50;
    localparam int TW    = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [15:0]   v_init = '0;
    logic [15:0]   v_high = '0;
    logic [15:0]   v_low = '0;
    logic [15:0]   step = '0;
    logic [TW-1:0] step_clks = '0;
    logic [7:0]    n_cycles = '0;
    logic [15:0]   dac_data;
    logic          sample_strobe;
    logic          busy;
    logic          done;
    logic          err;
    logic          dir;
    logic [7:0]    cycle_cnt;

    cv_sweep_scheduler #(
        .FRAME_CLKS (FRAME),
        .TIMER_W    (TW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .v_init        (v_init),
        .v_high        (v_high),
        .v_low         (v_low),
        .step          (step),
        .step_clks     (step_clks),
        .n_cycles      (n_cycles),
        .dac_data      (dac_data),
        .sample_strobe (sample_strobe),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .dir           (dir),
        .cycle_cnt     (cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int code;
        int dir;
        int cnt;
        int dwell;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mdl_dac = 0;
    int   mdl_cnt = 0;
    int   busy_total = 0;
    int   issued_n = 0;

    function automatic void chk(string name, int act, int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endfunction

    function automatic void push_s(int code, int d, int cnt, int dw);
        exp_t e;
        e.is_done = 1'b0; e.code = code; e.dir = d; e.cnt = cnt; e.dwell = dw; e.err = 0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_d(int e_err, int code, int cnt);
        exp_t e;
        e.is_done = 1'b1; e.code = code; e.dir = 0; e.cnt = cnt; e.dwell = 0; e.err = e_err;
        exp_q.push_back(e);
    endfunction

    task automatic scramble();
        v_init    = 16'($urandom);
        v_high    = 16'($urandom);
        v_low     = 16'($urandom);
        step      = 16'($urandom);
        step_clks = TW'($urandom);
        n_cycles  = 8'($urandom);
    endtask

    task automatic wait_queue(input int target, input int budget);
        int k = 0;
        while (exp_q.size() > target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() > target) begin
            chk("timeout_pending_events", exp_q.size(), target);
            exp_q.delete();
        end
    endtask

    // Build the expected sweep from the vertex rules, then launch it
    task automatic issue(input int vi, input int vh, input int vl, input int stp,
                         input int sclk, input int n, input bit wait_done);
        int s, dw, c;
        bit bad;
        bad = (vl > vi) || (vi > vh) || (n == 0);
        s   = (stp == 0) ? 1 : stp;
        dw  = (sclk < FRAME) ? FRAME : sclk;
        if (bad) begin
            push_d(1, mdl_dac, mdl_cnt);
        end else begin
            push_s(vi, 1, 0, dw);
            for (int k = 1; k <= n; k++) begin
                c = vi;
                while (c + s < vh) begin c = c + s; push_s(c, 1, k - 1, dw); end
                c = vh; push_s(c, 0, k - 1, dw);
                while (c - s > vl) begin c = c - s; push_s(c, 0, k - 1, dw); end
                c = vl; push_s(c, 1, k - 1, dw);
                while (c + s < vi) begin c = c + s; push_s(c, 1, k - 1, dw); end
                push_s(vi, 1, k, dw);
            end
            push_d(0, vi, n);
            mdl_dac = vi;
            mdl_cnt = n;
        end
        issued_n = exp_q.size();
        @(negedge clk);
        v_init = 16'(vi); v_high = 16'(vh); v_low = 16'(vl);
        step = 16'(stp); step_clks = TW'(sclk); n_cycles = 8'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        if (!bad) begin
            repeat (30) @(negedge clk);
            v_low = 16'd0; v_high = 16'hFFFF; n_cycles = 8'd5;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (wait_done) begin
            wait_queue(0, issued_n * (dw + 4) + 200);
            repeat (3) @(negedge clk);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes or completes
    initial begin : monitor
        int   dwell_cnt;
        int   cyc;
        int   last_strobe;
        exp_t e;
        dwell_cnt = 0; cyc = 0; last_strobe = -10;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                dwell_cnt = 0;
            end else begin
                if (busy) begin
                    dwell_cnt++;
                    busy_total++;
                end
                if (sample_strobe && done) chk("strobe_done_overlap", int'(done), 0);
                if (sample_strobe) begin
                    if (exp_q.size() == 0 || exp_q[0].is_done) begin
                        chk("unexpected_strobe", int'(sample_strobe), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("strobe_code", int'(dac_data), e.code);
                        chk("strobe_dir", int'(dir), e.dir);
                        chk("strobe_cycle_cnt", int'(cycle_cnt), e.cnt);
                        chk("dwell_len", dwell_cnt, e.dwell);
                        last_strobe = cyc;
                    end
                    dwell_cnt = 0;
                end
                if (!busy) dwell_cnt = 0;
                if (done) begin
                    if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                        chk("unexpected_done", int'(done), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_err", int'(err), e.err);
                        chk("done_busy", int'(busy), 0);
                        chk("done_code", int'(dac_data), e.code);
                        chk("done_cycle_cnt", int'(cycle_cnt), e.cnt);
                        if (e.err == 0) chk("done_latency", cyc - last_strobe, 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #6_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_dac", int'(dac_data), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_dir", int'(dir), 0);
        chk("reset_cycle_cnt", int'(cycle_cnt), 0);
        chk("reset_strobe", int'(sample_strobe), 0);

        // Basic sweep, clamped sweep, multi-cycle sweep
        busy_total = 0;
        issue(100, 130, 80, 10, 50, 1, 1);
        chk("basic_busy_cycles", busy_total, 550);
        issue(100, 130, 80, 7, 10, 1, 1);
        issue(100, 130, 80, 10, 50, 3, 1);

        // Abort during DOWN at code 110, then restart
        issue(100, 130, 80, 10, 50, 1, 0);
        wait_queue(issued_n - 5, 5 * 60 + 100);
        repeat (10) @(negedge clk);
        chk("pre_abort_code", int'(dac_data), 110);
        chk("pre_abort_dir", int'(dir), 0);
        abort = 1'b1;
        exp_q.delete();
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_dac", int'(dac_data), 100);
        chk("abort_cycle_cnt", int'(cycle_cnt), 0);
        mdl_dac = 100;
        mdl_cnt = 0;
        repeat (200) @(negedge clk);
        issue(100, 130, 80, 10, 50, 1, 1);

        // Configuration errors, then a valid start clears err
        issue(100, 130, 120, 10, 50, 1, 1);
        issue(100, 130, 80, 10, 50, 0, 1);
        issue(100, 130, 80, 10, 50, 1, 1);

        // start and abort together in IDLE: nothing starts
        @(negedge clk);
        v_init = 16'd200; v_high = 16'd230; v_low = 16'd180; step = 16'd10;
        step_clks = TW'(50); n_cycles = 8'd1;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (5) @(negedge clk);
        chk("start_abort_busy", int'(busy), 0);
        chk("start_abort_dac", int'(dac_data), mdl_dac);

        // Range boundaries, degenerate vertices, zero step
        issue(65530, 65535, 65520, 9000, 0, 1, 1);
        issue(3, 10, 0, 9000, 0, 1, 1);
        issue(500, 500, 500, 0, 0, 2, 1);
        issue(400, 402, 398, 0, 50, 1, 1);

        // Randomized configurations
        for (int r = 0; r < 6; r++) begin
            int vi, vh, vl, stp, sc, n;
            vi  = int'($urandom_range(1000, 60000));
            vh  = vi + int'($urandom_range(0, 40));
            vl  = vi - int'($urandom_range(0, 40));
            stp = int'($urandom_range(4, 20));
            sc  = int'($urandom_range(0, 90));
            n   = int'($urandom_range(1, 2));
            if (r == 2) vl = vi + 3;
            if (r == 4) vh = vi - 1;
            issue(vi, vh, vl, stp, sc, n, 1);
        end

        // Reset in the second sweep cycle
        issue(100, 130, 80, 10, 50, 2, 0);
        wait_queue(issued_n - 12, 13 * 60 + 100);
        repeat (5) @(negedge clk);
        chk("pre_reset_cycle_cnt", int'(cycle_cnt), 1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_dac", int'(dac_data), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_err", int'(err), 0);
        chk("midrst_cycle_cnt", int'(cycle_cnt), 0);
        mdl_dac = 0;
        mdl_cnt = 0;
        repeat (200) @(negedge clk);
        issue(100, 130, 80, 10, 50, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
